// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between the requesting blocks (master) and the
// round-robin arbiter (slave) guarding one shared datapath resource.
interface rr_resource_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    // Handshake: req[i] is a level request that stays high while requester i
    // wants the resource; grant[i] is the registered answer. Ownership lasts
    // while grant[i] is high and ends when the owner pulses done, drops req[i],
    // or the hold timeout expires. grant_id names the current or last owner.
    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            timeout_err;

    modport master (
        output req, done,
        input  grant, grant_id, busy, timeout_err
    );

    modport slave (
        input  req, done,
        output grant, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter: registered one-hot grant, held until done, request drop
// or hold timeout, followed by a mandatory one-cycle turnaround gap.
module rr_resource_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_resource_arbiter_if.slave arb,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [IDW:0]   NREQ_C    = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_C    = IDW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            busy_q, busy_d;
    logic            terr_q, terr_d;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [IDW:0]    idx;
    logic            owner_req;
    logic            at_limit;

    // Search ptr, ptr+1, ... wrapping at NREQ; the first set request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= NREQ_C) idx = idx - NREQ_C;
            if (!found && arb.req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    assign owner_req = arb.req[grant_id_q];
    assign at_limit  = (cnt_q == TIMEOUT_C);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        terr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (found) begin
                    grant_d    = NREQ'(1) << winner;
                    grant_id_d = winner;
                    busy_d     = 1'b1;
                    cnt_d      = CW'(1);
                    ptr_d      = (winner == LAST_C) ? '0 : winner + IDW'(1);
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (arb.done || !owner_req || at_limit) begin
                    // Only a release forced purely by the hold limit is an error.
                    terr_d  = !arb.done && owner_req;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_id    = grant_id_q;
    assign arb.busy        = busy_q;
    assign arb.timeout_err = terr_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Bench for rr_resource_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a request/ownership reference model.
module tb_rr_resource_arbiter;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;
    localparam int CW      = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    rr_resource_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    rr_resource_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected word: {grant[3:0], grant_id[1:0], busy, timeout_err}
    logic [7:0] exp_q[$];

    // reference model: who owns the resource, for how long, whose turn is next
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_gap   = 1'b0;
    int m_gid   = 0;
    bit m_terr  = 1'b0;

    task automatic model_step(input logic [3:0] r, input logic d, input logic rn);
        logic [3:0] g;
        bit         hit;
        if (!rn) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_gap = 1'b0; m_gid = 0; m_terr = 1'b0;
        end else if (m_owner >= 0) begin
            if (d || !r[m_owner] || m_held == TIMEOUT) begin
                m_terr  = (m_held == TIMEOUT) && !d && r[m_owner];
                m_owner = -1;
                m_held  = 0;
                m_gap   = 1'b1;
            end else begin
                m_held++;
                m_terr = 1'b0;
            end
        end else if (m_gap) begin
            m_gap  = 1'b0;
            m_terr = 1'b0;
        end else begin
            m_terr = 1'b0;
            hit    = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (!hit && r[w]) begin
                    hit     = 1'b1;
                    m_owner = w;
                    m_gid   = w;
                    m_held  = 1;
                    m_ptr   = (w + 1) % NREQ;
                end
            end
        end
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_q.push_back({g, 2'(m_gid), (m_owner >= 0), m_terr});
    endtask

    // driver: apply inputs for the next rising edge and record the expectation
    task automatic drive(input logic [3:0] r, input logic d, input logic rn);
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        rst_n    = rn;
        model_step(r, d, rn);
    endtask

    task automatic go_idle();
        for (int i = 0; i < 3; i++) drive(4'b0000, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [7:0] e;
        logic [7:0] a;
        logic       prev_terr;
        prev_terr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {bus.grant, bus.grant_id, bus.busy, bus.timeout_err};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: grant=%b id=%0d busy=%b terr=%b, expected grant=%b id=%0d busy=%b terr=%b",
                             $time, a[7:4], a[3:2], a[1], a[0], e[7:4], e[3:2], e[1], e[0]);
                end
                n_checks++;
                if (!$onehot0(bus.grant) || (bus.busy !== |bus.grant) || (prev_terr && bus.timeout_err)) begin
                    n_fail++;
                    $display("FAIL invariant @%0t: grant=%b busy=%b terr=%b prev_terr=%b",
                             $time, bus.grant, bus.busy, bus.timeout_err, prev_terr);
                end
                prev_terr = bus.timeout_err;
            end
        end
    end

    // stimulus
    initial begin
        int gcnt;
        int tcnt;
        logic [3:0] r;
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;

        // reset held with all requests high, then first grant goes to 0
        for (int i = 0; i < 3; i++) drive(4'b1111, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b1);

        // rotation: every owner releases on its second grant cycle
        for (int i = 0; i < 22; i++)
            drive(4'b1111, (m_owner >= 0 && m_held == 2), 1'b1);

        // pointer skip: serve requester 1, then only requester 0 asks
        go_idle();
        for (int i = 0; i < 3; i++) drive(4'b0010, (m_owner >= 0 && m_held == 2), 1'b1);
        for (int i = 0; i < 4; i++) drive(4'b0001, 1'b0, 1'b1);

        // timeout: requester 2 never releases
        go_idle();
        gcnt = 0;
        tcnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive((i < 17) ? 4'b0100 : 4'b0000, 1'b0, 1'b1);
            if (bus.grant == 4'b0100) gcnt++;
            if (bus.timeout_err) tcnt++;
        end
        chk("timeout_hold_cycles", gcnt, TIMEOUT);
        chk("timeout_err_pulses", tcnt, 1);

        // done arriving on the last allowed hold cycle is a normal release
        go_idle();
        tcnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive((i < 17) ? 4'b0100 : 4'b0000, (m_owner >= 0 && m_held == TIMEOUT), 1'b1);
            if (bus.timeout_err) tcnt++;
        end
        chk("collision_err_pulses", tcnt, 0);

        // requester drops its request mid-grant
        go_idle();
        tcnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive((i < 6) ? 4'b0010 : 4'b0000, 1'b0, 1'b1);
            if (bus.timeout_err) tcnt++;
        end
        chk("drop_err_pulses", tcnt, 0);

        // reset while requester 3 owns the resource; pointer restarts at 0
        go_idle();
        for (int i = 0; i < 3; i++) drive(4'b1000, 1'b0, 1'b1);
        drive(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(4'b1010, 1'b0, 1'b1);
        chk("post_reset_grant", int'(bus.grant), int'(4'b0010));

        // random traffic
        r = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
            drive(r, (m_owner >= 0) && ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 99) != 0));
        end
        go_idle();

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
